jtag_bus_bridge: RTL and testbench

- Consumes fully shifted JTAG USER1 request words {we, addr[31:0], data[31:0]} after they are synchronised into the system clock domain.
- Turns each request into one transaction on the internal memory/peripheral bus, or serves it from a local control register.
- Latches the completed transaction as the response word captured on the next JTAG shift, so read data appears one shift later.
- Owns the core reset control register at CTRL_ADDR.

---
 rtl/jtag_bus_bridge_if.sv | 34 +++
 rtl/jtag_bus_bridge.sv | 129 ++++++++++++
 tb/tb_jtag_bus_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_bus_bridge_if.sv
// Request, response and internal-bus signal bundle of the JTAG-to-bus bridge.
// The slave modport is the bridge side; master is the JTAG/bus environment side.
interface jtag_bus_bridge_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_data;

  logic        resp_we;
  logic [31:0] resp_addr;
  logic [31:0] resp_data;
  logic        resp_valid;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_data,
    input  resp_we, resp_addr, resp_data, resp_valid,
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data,
    output resp_we, resp_addr, resp_data, resp_valid,
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );
endinterface

// File: rtl/jtag_bus_bridge.sv
// Turns synchronised JTAG request words into single bus transactions or local
// control-register accesses, and latches the result as the next response word.
module jtag_bus_bridge #(
  parameter logic [31:0] CTRL_ADDR      = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             resetb,
  jtag_bus_bridge_if.slave link,
  output logic             core_resetb,
  output logic             overflow,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic          pend_valid;
  logic          pend_we;
  logic [31:0]   pend_addr;
  logic [31:0]   pend_data;
  logic          txn_we;
  logic [31:0]   txn_addr;
  logic [31:0]   result;
  logic [CW-1:0] cnt;

  logic consume, drop, ctrl_wr, ovf_clr, tmo_clr, tmo_set;

  always_comb begin
    consume = (state == IDLE) && pend_valid;
    drop    = link.req_valid && pend_valid && !consume;
    ctrl_wr = consume && pend_we && (pend_addr == CTRL_ADDR);
    ovf_clr = ctrl_wr && pend_data[1];
    tmo_clr = ctrl_wr && pend_data[2];
    tmo_set = (state == ISSUE) && !link.bus_ack && (cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state           <= IDLE;
      pend_valid      <= 1'b0;
      pend_we         <= 1'b0;
      pend_addr       <= '0;
      pend_data       <= '0;
      txn_we          <= 1'b0;
      txn_addr        <= '0;
      result          <= '0;
      cnt             <= '0;
      core_resetb     <= 1'b0;
      overflow        <= 1'b0;
      timeout         <= 1'b0;
      link.resp_we    <= 1'b0;
      link.resp_addr  <= '0;
      link.resp_data  <= '0;
      link.resp_valid <= 1'b0;
      link.bus_req    <= 1'b0;
      link.bus_we     <= 1'b0;
      link.bus_addr   <= '0;
      link.bus_wdata  <= '0;
    end else begin
      link.resp_valid <= 1'b0;
      // A set wins over a clear landing on the same edge.
      overflow <= (overflow & ~ovf_clr) | drop;
      timeout  <= (timeout & ~tmo_clr) | tmo_set;

      if (link.req_valid && (!pend_valid || consume)) begin
        pend_valid <= 1'b1;
        pend_we    <= link.req_we;
        pend_addr  <= link.req_addr;
        pend_data  <= link.req_data;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pend_valid) begin
            txn_we   <= pend_we;
            txn_addr <= pend_addr;
            if (pend_addr == CTRL_ADDR) begin
              if (pend_we) begin
                core_resetb <= pend_data[0];
                result      <= pend_data;
              end else begin
                result <= {29'b0, timeout, overflow, core_resetb};
              end
              state <= RESP;
            end else begin
              // Write data doubles as the write result; reads overwrite it.
              result         <= pend_data;
              link.bus_req   <= 1'b1;
              link.bus_we    <= pend_we;
              link.bus_addr  <= pend_addr;
              link.bus_wdata <= pend_data;
              cnt            <= '0;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (link.bus_ack) begin
            link.bus_req <= 1'b0;
            if (!txn_we) result <= link.bus_rdata;
            state <= RESP;
          end else if (cnt == LAST) begin
            link.bus_req <= 1'b0;
            if (!txn_we) result <= TIMEOUT_DATA;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          link.resp_we    <= txn_we;
          link.resp_addr  <= txn_addr;
          link.resp_data  <= result;
          link.resp_valid <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_bus_bridge.sv
// Bench for jtag_bus_bridge: directed scenarios plus randomized traffic checked
// every cycle against a schedule-based transaction model.
module tb_jtag_bus_bridge;
  localparam logic [31:0] CTRL  = 32'h1000_0000;
  localparam int          TMO   = 1024;
  localparam logic [31:0] TDATA = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic core_resetb, overflow, timeout;

  jtag_bus_bridge_if link();

  jtag_bus_bridge #(
    .CTRL_ADDR(CTRL),
    .TIMEOUT_CYCLES(TMO),
    .TIMEOUT_DATA(TDATA)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .link(link.slave),
    .core_resetb(core_resetb),
    .overflow(overflow),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Each accepted request becomes a record with the edges at which it is
  // consumed (s), acked/timed out (e) and reported (rsp).
  typedef struct {
    bit          we;
    bit          loc;
    bit          to;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [31:0] result;
    int          s;
    int          e;
    int          rsp;
  } rec_t;

  rec_t recs[$];
  int   drops[$];
  int   free_edge = 0;
  int   last_s = 0;
  bit   m_core = 0, m_ovf = 0, m_tmo = 0;
  bit   x_rv = 0, x_rwe = 0, x_breq = 0, x_bwe = 0;
  logic [31:0] x_raddr = '0, x_rdata = '0, x_baddr = '0, x_bwdata = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_reset();
    recs.delete();
    drops.delete();
    free_edge = 0;
    last_s = 0;
    m_core = 0; m_ovf = 0; m_tmo = 0;
    x_rv = 0; x_rwe = 0; x_breq = 0; x_bwe = 0;
    x_raddr = '0; x_rdata = '0; x_baddr = '0; x_bwdata = '0;
  endfunction

  function automatic void model_accept(int nk, bit we, logic [31:0] a, logic [31:0] d,
                                       logic [31:0] rd, int w);
    rec_t r;
    if (last_s > nk) begin
      drops.push_back(nk);
      return;
    end
    r.we = we; r.addr = a; r.data = d; r.rdata = rd;
    r.loc = (a == CTRL);
    r.s = (nk + 1 > free_edge) ? nk + 1 : free_edge;
    if (r.loc) begin
      r.to = 0;
      r.e = r.s;
      r.rsp = r.s + 1;
      r.result = d;
    end else begin
      r.to = (w >= TMO);
      r.e = r.to ? r.s + TMO : r.s + 1 + w;
      r.rsp = r.e + 1;
      r.result = we ? d : (r.to ? TDATA : rd);
    end
    free_edge = r.rsp + 1;
    last_s = r.s;
    recs.push_back(r);
  endfunction

  function automatic void model_edge(int k);
    bit so = 0, co = 0, st = 0, ct = 0;
    bit nc = m_core;
    foreach (drops[i]) if (drops[i] == k) so = 1;
    x_rv = 0;
    x_breq = 0;
    foreach (recs[i]) begin
      if (recs[i].loc && recs[i].s == k) begin
        if (recs[i].we) begin
          nc = recs[i].data[0];
          co = recs[i].data[1];
          ct = recs[i].data[2];
        end else begin
          recs[i].result = {29'b0, m_tmo, m_ovf, m_core};
        end
      end
      if (!recs[i].loc && recs[i].to && recs[i].e == k) st = 1;
      if (recs[i].rsp == k) begin
        x_rv = 1;
        x_rwe = recs[i].we;
        x_raddr = recs[i].addr;
        x_rdata = recs[i].result;
      end
      if (!recs[i].loc && recs[i].s <= k && k < recs[i].e) begin
        x_breq = 1;
        x_bwe = recs[i].we;
        x_baddr = recs[i].addr;
        x_bwdata = recs[i].data;
      end
    end
    m_core = nc;
    m_ovf = (m_ovf & !co) | so;
    m_tmo = (m_tmo & !ct) | st;
    while (recs.size() > 0 && recs[0].rsp <= k) recs.delete(0);
    while (drops.size() > 0 && drops[0] <= k) drops.delete(0);
  endfunction

  function automatic void drive_bus(int nk);
    link.bus_ack = 1'b0;
    link.bus_rdata = $urandom;
    foreach (recs[i])
      if (!recs[i].loc && !recs[i].to && recs[i].e == nk) begin
        link.bus_ack = 1'b1;
        link.bus_rdata = recs[i].rdata;
      end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("resp_valid", 32'(link.resp_valid), 32'(x_rv));
      check("resp_we", 32'(link.resp_we), 32'(x_rwe));
      check("resp_addr", link.resp_addr, x_raddr);
      check("resp_data", link.resp_data, x_rdata);
      check("bus_req", 32'(link.bus_req), 32'(x_breq));
      check("core_resetb", 32'(core_resetb), 32'(m_core));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("timeout", 32'(timeout), 32'(m_tmo));
      if (x_breq) begin
        check("bus_we", 32'(link.bus_we), 32'(x_bwe));
        check("bus_addr", link.bus_addr, x_baddr);
        check("bus_wdata", link.bus_wdata, x_bwdata);
      end
    end
  end

  task automatic step(input bit v, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] rd, input int w, input bit rst);
    int nk;
    nk = cyc + 1;
    resetb = !rst;
    link.req_valid = v;
    link.req_we = we;
    link.req_addr = a;
    link.req_data = d;
    if (v && !rst) model_accept(nk, we, a, d, rd, w);
    drive_bus(nk);
    @(posedge clk);
    cyc = nk;
    if (rst) model_reset();
    else model_edge(cyc);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 0, 1'b0);
  endtask

  task automatic wait_resp(input int max, output int lat, output int req_cycles);
    lat = 0;
    req_cycles = 0;
    do begin
      idle();
      lat++;
      if (link.bus_req) req_cycles++;
    end while (!link.resp_valid && lat < max);
    if (!link.resp_valid) check("resp_wait_budget", 32'(link.resp_valid), 32'd1);
  endtask

  initial begin
    int lat, nr, got, ntmo, w;
    logic [31:0] a;

    link.req_valid = 0; link.req_we = 0; link.req_addr = '0; link.req_data = '0;
    link.bus_ack = 0; link.bus_rdata = '0;
    chk_en = 1'b1;

    step(0, 0, '0, '0, '0, 0, 1);
    step(0, 0, '0, '0, '0, 0, 1);
    check("rst_core_resetb", 32'(core_resetb), 32'd0);
    check("rst_bus_req", 32'(link.bus_req), 32'd0);

    // Local control write, then read back.
    step(1, 1, CTRL, 32'h1, '0, 0, 0);
    wait_resp(10, lat, nr);
    check("ctrl_wr_latency", 32'(lat), 32'd2);
    check("ctrl_wr_resp_we", 32'(link.resp_we), 32'd1);
    check("ctrl_wr_resp_addr", link.resp_addr, 32'h1000_0000);
    check("ctrl_wr_resp_data", link.resp_data, 32'h1);
    check("ctrl_wr_core", 32'(core_resetb), 32'd1);
    step(1, 0, CTRL, '0, '0, 0, 0);
    wait_resp(10, lat, nr);
    check("ctrl_rd_latency", 32'(lat), 32'd2);
    check("ctrl_rd_data", link.resp_data, 32'h1);

    // Bus write with three wait cycles, then bus read.
    step(1, 1, 32'h0000_1004, 32'hA5A5_5A5A, '0, 3, 0);
    wait_resp(20, lat, nr);
    check("bus_wr_req_cycles", 32'(nr), 32'd4);
    check("bus_wr_latency", 32'(lat), 32'd6);
    check("bus_wr_resp_data", link.resp_data, 32'hA5A5_5A5A);
    step(1, 0, 32'h0000_1004, '0, 32'hA5A5_5A5A, 0, 0);
    wait_resp(20, lat, nr);
    check("bus_rd_latency", 32'(lat), 32'd3);
    check("bus_rd_resp_data", link.resp_data, 32'hA5A5_5A5A);
    check("bus_rd_resp_we", 32'(link.resp_we), 32'd0);

    // Three back-to-back requests: the third arrives while the buffer is full.
    step(1, 1, 32'h0000_2000, 32'h11, '0, 5, 0);
    step(1, 0, 32'h0000_2004, '0, 32'h22, 5, 0);
    step(1, 1, 32'h0000_2008, 32'h33, '0, 5, 0);
    check("b2b_overflow", 32'(overflow), 32'd1);
    got = 0;
    for (int i = 0; i < 40 && got < 2; i++) begin
      idle();
      if (link.resp_valid) begin
        if (got == 0) check("b2b_first_addr", link.resp_addr, 32'h0000_2000);
        else begin
          check("b2b_second_addr", link.resp_addr, 32'h0000_2004);
          check("b2b_second_data", link.resp_data, 32'h22);
        end
        got++;
      end
    end
    check("b2b_count", 32'(got), 32'd2);
    step(1, 0, CTRL, '0, '0, 0, 0);
    wait_resp(10, lat, nr);
    check("ctrl_status_ovf", link.resp_data, 32'h3);
    step(1, 1, CTRL, 32'h7, '0, 0, 0);
    wait_resp(10, lat, nr);
    check("ctrl_clear_ovf", 32'(overflow), 32'd0);
    check("ctrl_clear_core", 32'(core_resetb), 32'd1);

    // Ack on the last count cycle is a normal ack.
    step(1, 0, 32'h0000_3000, '0, 32'h1234_5678, TMO - 1, 0);
    wait_resp(1100, lat, nr);
    check("late_ack_req_cycles", 32'(nr), 32'd1024);
    check("late_ack_data", link.resp_data, 32'h1234_5678);
    check("late_ack_no_timeout", 32'(timeout), 32'd0);

    // No ack at all.
    step(1, 0, 32'h2000_0000, '0, '0, TMO, 0);
    wait_resp(1100, lat, nr);
    check("tmo_req_cycles", 32'(nr), 32'd1024);
    check("tmo_data", link.resp_data, 32'hDEAD_BEEF);
    check("tmo_flag", 32'(timeout), 32'd1);
    step(1, 1, 32'h0000_4000, 32'h77, '0, 0, 0);
    wait_resp(10, lat, nr);
    check("after_tmo_latency", 32'(lat), 32'd3);
    check("after_tmo_data", link.resp_data, 32'h77);

    // Second request lands on the consuming edge of the first.
    step(1, 1, 32'h0000_5000, 32'h1, '0, 0, 0);
    step(1, 0, CTRL, '0, '0, 0, 0);
    check("same_edge_no_ovf", 32'(overflow), 32'd0);
    wait_resp(10, lat, nr);
    wait_resp(10, lat, nr);
    check("same_edge_status", link.resp_data, 32'h5);

    // Reset while a bus transaction is outstanding.
    step(1, 1, 32'h0000_6000, 32'h99, '0, 50, 0);
    idle(); idle(); idle();
    check("mid_issue_req", 32'(link.bus_req), 32'd1);
    step(0, 0, '0, '0, '0, 0, 1);
    check("rst_issue_req", 32'(link.bus_req), 32'd0);
    check("rst_issue_core", 32'(core_resetb), 32'd0);
    check("rst_issue_tmo", 32'(timeout), 32'd0);
    check("rst_issue_ovf", 32'(overflow), 32'd0);
    step(1, 1, CTRL, 32'h1, '0, 0, 0);
    wait_resp(10, lat, nr);
    step(1, 1, 32'h0000_6000, 32'h99, '0, 2, 0);
    wait_resp(20, lat, nr);
    check("post_rst_latency", 32'(lat), 32'd5);
    check("post_rst_data", link.resp_data, 32'h99);

    // Randomized traffic, checked every cycle by the compare process.
    ntmo = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        step(0, 0, '0, '0, '0, 0, 1);
      end else if ($urandom_range(0, 99) < 35) begin
        a = $urandom;
        if (a == CTRL) a = a ^ 32'h1;
        if ($urandom_range(0, 3) == 0) a = CTRL;
        w = $urandom_range(0, 6);
        if (a != CTRL && ntmo < 2 && $urandom_range(0, 299) == 0) begin
          w = TMO;
          ntmo++;
        end
        step(1, 1'($urandom_range(0, 1)), a, $urandom, $urandom, w, 0);
      end else begin
        idle();
      end
    end
    for (int i = 0; i < 1100; i++) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
